hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It consumes the per-stage register tags and control flags exported by the datapath, and returns the stall, flush and forward selects that drive the F/D/E stages. Forwarding and load/branch interlocks are combinational. A registered state machine tracks the iterative multiplier so HI/LO readers and back-to-back multiplies interlock correctly. A watchdog guards against a multiplier that never completes.

## Interface
- `MULT_TIMEOUT`, 64: maximum cycles in BUSY before the watchdog fires (≥ 2).
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-low reset.
- `branchD` in 2: non-zero = branch in Decode.
- `RsD`, `RtD` in 5 each: Decode source registers.
- `MultStartD` in 1: Decode holds a mult/multu.
- `MultReadD` in 1: Decode holds mfhi/mflo.
- `RsE`, `RtE`, `WriteRegE` in 5 each: Execute tags.
- `RegWriteE` in 1; `WBSrcE` in 3: Execute writeback flags.
- `MultStartE`, `MultDoneE` in 1 each: multiplier launch (one cycle) and completion (one cycle).
- `WriteRegM` in 5; `RegWriteM` in 1; `WBSrcM` in 3: Memory tags.
- `WriteRegW` in 5; `RegWriteW` in 1: Writeback tags.
- `stallF`, `stallD`, `flushE` out 1 each.
- `forwardAD`, `forwardBD` out 1 each: Decode comparator bypass from M.
- `forwardAE`, `forwardBE` out 2 each: 00 regfile, 01 W result, 10 M ALU/mult output.
- `multBusy` out 1: FSM in BUSY.
- `multTimeout` out 1: sticky watchdog error.

## Operation
- Register 0 never matches in any comparison.
- Execute forwarding, evaluated for `RsE` and `RtE` independently:
  - select 10 if the tag equals `WriteRegM` and `RegWriteM`;
  - else 01 if it equals `WriteRegW` and `RegWriteW`;
  - else 00. M has priority over W.
- Decode bypass: `forwardAD` = `RsD` equals `WriteRegM` and `RegWriteM`. `forwardBD` is the same for `RtD`.
- Load stall `lwstall`: `WBSrcE` is `WB_MEM`, `RegWriteE` is set, and `WriteRegE` equals `RsD` or `RtD`.
- Branch stall `brstall`: `branchD` is non-zero and either
  - `RegWriteE` is set and `WriteRegE` equals `RsD` or `RtD`, or
  - `WBSrcM` is `WB_MEM`, `RegWriteM` is set and `WriteRegM` equals `RsD` or `RtD`.
- Multiplier FSM, states IDLE and BUSY:
  - IDLE → BUSY on `MultStartE`; the timer clears.
  - BUSY → IDLE on `MultDoneE`.
  - BUSY with `MultStartE` and `MultDoneE` together: stay BUSY and clear the timer (back-to-back multiply).
  - BUSY with neither: timer increments.
  - When the timer reaches `MULT_TIMEOUT - 1` in BUSY: go to IDLE and set `multTimeout`.
  - `multTimeout` clears only on reset.
- Effective busy: `busyEff` = (BUSY and not `MultDoneE`) or `MultStartE`.
- Multiply stall: `multstall` = (`MultReadD` or `MultStartD`) and `busyEff`.
- Stall combine:
  - `stallF` = `stallD` = `flushE` = `lwstall` | `brstall` | `multstall`.
  - `multBusy` = FSM in BUSY.
- Timer width is `$clog2(MULT_TIMEOUT)`. It never wraps; the timeout transition takes precedence over increment.

## Timing
- All stall, forward and flush outputs are combinational from the inputs and the FSM state, valid in the same cycle.
- FSM and timer update on the rising `clk` edge.
- A `MultDoneE` cycle releases HI/LO readers in that same cycle; the reader enters E on the next edge.
- Reset, asynchronous and immediate, including mid-multiply:
  - FSM returns to IDLE, timer to 0, `multTimeout` to 0, `multBusy` to 0.
  - With all inputs 0, every output is 0.
- Asynchronous assert, with no synchronous release logic inside the block.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds out 32 `perfStallCycles`: counts cycles with `stallD` high.
  - Adds out 32 `perfMultStall`: counts cycles with `multstall` high.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither the ports nor the counters exist, and all other behaviour is unchanged.

## Structure
- Shared package `mips_pkg`:
  - `WBSrc` encodings: `WB_ALU`=3'b000, `WB_MEM`=3'b001, `WB_HI`=3'b010, `WB_LO`=3'b011, `WB_PC8`=3'b100.
  - Forward-select constants `FWD_RF`, `FWD_W`, `FWD_M`.
  - The multiplier FSM state enum.
- One sub-module, `mult_tracker`, holds the FSM, the timer and the watchdog, and outputs `busyEff`, `multBusy` and `multTimeout`.
- The comparators and stall combine stay in `hazard_unit`.

## Test plan
- Forward priority:
  - `RsE`=5, `WriteRegM`=5, `RegWriteM`=1, `WriteRegW`=5, `RegWriteW`=1 → `forwardAE`=10.
  - Drop `RegWriteM` → `forwardAE`=01.
  - Set `RsE`=0 → `forwardAE`=00.
- Load-use: `WBSrcE`=001, `RegWriteE`=1, `WriteRegE`=8, `RtD`=8 → `stallF`=`stallD`=`flushE`=1. Set `WriteRegE`=9 → all 0.
- Branch: `branchD`=01, `RsD`=3, `RegWriteE`=1, `WriteRegE`=3 → stall. Move the producer to M as an ALU op (`WBSrcM`=000) → no stall, `forwardAD`=1.
- Multiply:
  - Pulse `MultStartE`, hold `MultReadD`=1 → stall for 4 cycles, `multBusy`=1.
  - Pulse `MultDoneE` at cycle 5 → stall drops that cycle; `multBusy`=0 next cycle.
- Watchdog, `MULT_TIMEOUT`=8:
  - Pulse `MultStartE` with no done → `multTimeout`=1 and `multBusy`=0 after 8 cycles; the error stays sticky.
  - Assert `rst` low mid-BUSY → `multBusy`=0 immediately, before the next clock edge.
- With `HAZARD_PERF_CNT_EN`: 10 load-use stall cycles → `perfStallCycles`=10, `perfMultStall`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the five-stage MIPS core: writeback sources,
// forward selects, multiplier tracker states and a tag-compare helper.
package mips_pkg;

    typedef enum logic [2:0] {
        WB_ALU = 3'b000,
        WB_MEM = 3'b001,
        WB_HI  = 3'b010,
        WB_LO  = 3'b011,
        WB_PC8 = 3'b100
    } wbSrc_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [0:0] {
        MULT_IDLE = 1'b0,
        MULT_BUSY = 1'b1
    } multState_t;

    // $zero is hard-wired, so a write to it can never be a real producer.
    function automatic logic tagMatch(input logic [4:0] srcTag,
                                      input logic       writeEn,
                                      input logic [4:0] dstTag);
        return writeEn && (srcTag != 5'd0) && (srcTag == dstTag);
    endfunction

endpackage

// File: rtl/mult_tracker.sv
// Tracks the iterative multiplier (IDLE/BUSY) with a sticky watchdog that
// abandons a multiply which never signals completion.
module mult_tracker
    import mips_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic MultStartE,
    input  logic MultDoneE,
    output logic busyEff,
    output logic multBusy,
    output logic multTimeout
);

    localparam int TW = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MULT_TIMEOUT - 1);

    multState_t    state;
    multState_t    stateNext;
    logic [TW-1:0] timer;
    logic [TW-1:0] timerNext;
    logic          timeoutNext;

    // A launch while BUSY is a back-to-back multiply: stay BUSY, restart the timer.
    always_comb begin
        stateNext   = state;
        timerNext   = timer;
        timeoutNext = multTimeout;
        case (state)
            MULT_IDLE: begin
                if (MultStartE) begin
                    stateNext = MULT_BUSY;
                    timerNext = '0;
                end
            end
            MULT_BUSY: begin
                if (MultStartE) begin
                    timerNext = '0;
                end else if (MultDoneE) begin
                    stateNext = MULT_IDLE;
                    timerNext = '0;
                end else if (timer == TIMER_LAST) begin
                    stateNext   = MULT_IDLE;
                    timerNext   = '0;
                    timeoutNext = 1'b1;
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            default: begin
                stateNext = MULT_IDLE;
                timerNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= MULT_IDLE;
            timer       <= '0;
            multTimeout <= 1'b0;
        end else begin
            state       <= stateNext;
            timer       <= timerNext;
            multTimeout <= timeoutNext;
        end
    end

    assign multBusy = (state == MULT_BUSY);
    assign busyEff  = (multBusy && !MultDoneE) || MultStartE;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the five-stage MIPS pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall performance counters.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] branchD,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       MultStartD,
    input  logic       MultReadD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteE,
    input  logic [2:0] WBSrcE,
    input  logic       MultStartE,
    input  logic       MultDoneE,
    input  logic [4:0] WriteRegM,
    input  logic       RegWriteM,
    input  logic [2:0] WBSrcM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteW,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       multBusy,
    output logic       multTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perfStallCycles,
    output logic [31:0] perfMultStall
`endif
);

    logic busyEff;
    logic lwstall;
    logic brstall;
    logic multstall;
    logic stallAny;

    mult_tracker #(
        .MULT_TIMEOUT(MULT_TIMEOUT)
    ) uMultTracker (
        .clk        (clk),
        .rst        (rst),
        .MultStartE (MultStartE),
        .MultDoneE  (MultDoneE),
        .busyEff    (busyEff),
        .multBusy   (multBusy),
        .multTimeout(multTimeout)
    );

    // M is the younger producer, so it wins over W.
    always_comb begin
        forwardAE = FWD_RF;
        if (tagMatch(RsE, RegWriteM, WriteRegM)) begin
            forwardAE = FWD_M;
        end else if (tagMatch(RsE, RegWriteW, WriteRegW)) begin
            forwardAE = FWD_W;
        end
    end

    always_comb begin
        forwardBE = FWD_RF;
        if (tagMatch(RtE, RegWriteM, WriteRegM)) begin
            forwardBE = FWD_M;
        end else if (tagMatch(RtE, RegWriteW, WriteRegW)) begin
            forwardBE = FWD_W;
        end
    end

    assign forwardAD = tagMatch(RsD, RegWriteM, WriteRegM);
    assign forwardBD = tagMatch(RtD, RegWriteM, WriteRegM);

    assign lwstall = (WBSrcE == WB_MEM) &&
                     (tagMatch(RsD, RegWriteE, WriteRegE) ||
                      tagMatch(RtD, RegWriteE, WriteRegE));

    // Branches resolve in Decode, so any E producer or an M load must settle first.
    assign brstall = (branchD != 2'b00) &&
                     (tagMatch(RsD, RegWriteE, WriteRegE) ||
                      tagMatch(RtD, RegWriteE, WriteRegE) ||
                      ((WBSrcM == WB_MEM) &&
                       (tagMatch(RsD, RegWriteM, WriteRegM) ||
                        tagMatch(RtD, RegWriteM, WriteRegM))));

    assign multstall = (MultReadD || MultStartD) && busyEff;

    assign stallAny = lwstall || brstall || multstall;
    assign stallF   = stallAny;
    assign stallD   = stallAny;
    assign flushE   = stallAny;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perfStallCycles <= '0;
            perfMultStall   <= '0;
        end else begin
            if (stallD && (perfStallCycles != 32'hFFFF_FFFF)) begin
                perfStallCycles <= perfStallCycles + 32'd1;
            end
            if (multstall && (perfMultStall != 32'hFFFF_FFFF)) begin
                perfMultStall <= perfMultStall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (watchdog at MULT_TIMEOUT=8);
// define HAZARD_PERF_CNT_EN to also exercise the performance counters.
module tb_hazard_unit;

    localparam int TIMEOUT = 8;

    logic       clk;
    logic       rst;
    logic [1:0] branchD;
    logic [4:0] RsD, RtD;
    logic       MultStartD, MultReadD;
    logic [4:0] RsE, RtE, WriteRegE;
    logic       RegWriteE;
    logic [2:0] WBSrcE;
    logic       MultStartE, MultDoneE;
    logic [4:0] WriteRegM;
    logic       RegWriteM;
    logic [2:0] WBSrcM;
    logic [4:0] WriteRegW;
    logic       RegWriteW;
    logic       stallF, stallD, flushE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       multBusy, multTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perfStallCycles, perfMultStall;
`endif

    int testCount = 0;
    int failCount = 0;

    hazard_unit #(
        .MULT_TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .branchD    (branchD),
        .RsD        (RsD),
        .RtD        (RtD),
        .MultStartD (MultStartD),
        .MultReadD  (MultReadD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .RegWriteE  (RegWriteE),
        .WBSrcE     (WBSrcE),
        .MultStartE (MultStartE),
        .MultDoneE  (MultDoneE),
        .WriteRegM  (WriteRegM),
        .RegWriteM  (RegWriteM),
        .WBSrcM     (WBSrcM),
        .WriteRegW  (WriteRegW),
        .RegWriteW  (RegWriteW),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushE     (flushE),
        .forwardAD  (forwardAD),
        .forwardBD  (forwardBD),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .multBusy   (multBusy),
        .multTimeout(multTimeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perfStallCycles(perfStallCycles),
        .perfMultStall  (perfMultStall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        branchD = 2'b00; RsD = 5'd0; RtD = 5'd0;
        MultStartD = 1'b0; MultReadD = 1'b0;
        RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0; RegWriteE = 1'b0; WBSrcE = 3'b000;
        MultStartE = 1'b0; MultDoneE = 1'b0;
        WriteRegM = 5'd0; RegWriteM = 1'b0; WBSrcM = 3'b000;
        WriteRegW = 5'd0; RegWriteW = 1'b0;
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] stalls();
        return {stallF, stallD, flushE};
    endfunction

    initial begin
        rst = 1'b0;
        clearInputs();
        #2;
        checkOutput("resetAll", {22'd0, stallF, stallD, flushE, forwardAD, forwardBD,
                    forwardAE, forwardBE, multBusy, multTimeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Execute forwarding priority
        applyStimulus();
        RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1; WriteRegW = 5'd5; RegWriteW = 1'b1;
        #1;
        checkOutput("fwdAE_M", {30'd0, forwardAE}, 32'd2);
        checkOutput("fwdBE_none", {30'd0, forwardBE}, 32'd0);
        checkOutput("fwdNoStall", {29'd0, stalls()}, 32'd0);
        RegWriteM = 1'b0;
        #1;
        checkOutput("fwdAE_W", {30'd0, forwardAE}, 32'd1);
        RsE = 5'd0;
        #1;
        checkOutput("fwdAE_r0", {30'd0, forwardAE}, 32'd0);
        RtE = 5'd5; RegWriteM = 1'b1;
        #1;
        checkOutput("fwdBE_M", {30'd0, forwardBE}, 32'd2);
        checkOutput("fwdAE_indep", {30'd0, forwardAE}, 32'd0);
        clearInputs();

        // Load-use interlock
        WBSrcE = 3'b001; RegWriteE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
        #1;
        checkOutput("lwStall", {29'd0, stalls()}, 32'd7);
        WriteRegE = 5'd9;
        #1;
        checkOutput("lwNoMatch", {29'd0, stalls()}, 32'd0);
        WriteRegE = 5'd0; RtD = 5'd0;
        #1;
        checkOutput("lwReg0", {29'd0, stalls()}, 32'd0);
        WriteRegE = 5'd8; RtD = 5'd8; WBSrcE = 3'b000;
        #1;
        checkOutput("aluNoStall", {29'd0, stalls()}, 32'd0);
        clearInputs();

        // Branch interlock and decode bypass
        branchD = 2'b01; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
        #1;
        checkOutput("brStallE", {29'd0, stalls()}, 32'd7);
        RegWriteE = 1'b0; WriteRegE = 5'd0; WriteRegM = 5'd3; RegWriteM = 1'b1; WBSrcM = 3'b000;
        #1;
        checkOutput("brAluM", {29'd0, stalls()}, 32'd0);
        checkOutput("fwdAD_BD", {30'd0, forwardAD, forwardBD}, 32'd2);
        WBSrcM = 3'b001;
        #1;
        checkOutput("brLoadM", {29'd0, stalls()}, 32'd7);
        branchD = 2'b00;
        #1;
        checkOutput("noBrLoadM", {29'd0, stalls()}, 32'd0);
        clearInputs();

        // Multiply: reader held in Decode until done
        applyStimulus();
        MultStartE = 1'b1; MultReadD = 1'b1;
        #1;
        checkOutput("multC0Stall", {31'd0, stallD}, 32'd1);
        checkOutput("multC0Busy", {31'd0, multBusy}, 32'd0);
        applyStimulus();
        MultStartE = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checkOutput($sformatf("multC%0dStall", i), {31'd0, stallD}, 32'd1);
            checkOutput($sformatf("multC%0dBusy", i), {31'd0, multBusy}, 32'd1);
            applyStimulus();
        end
        MultDoneE = 1'b1;
        #1;
        checkOutput("multDoneStall", {31'd0, stallD}, 32'd0);
        checkOutput("multDoneBusy", {31'd0, multBusy}, 32'd1);
        applyStimulus();
        MultDoneE = 1'b0;
        #1;
        checkOutput("multAfterBusy", {31'd0, multBusy}, 32'd0);
        checkOutput("multAfterStall", {31'd0, stallD}, 32'd0);
        clearInputs();

        // Back-to-back multiply keeps the tracker busy
        MultStartE = 1'b1;
        applyStimulus();
        MultStartE = 1'b0; MultStartD = 1'b1;
        #1;
        checkOutput("b2bStall", {31'd0, stallD}, 32'd1);
        MultStartE = 1'b1; MultDoneE = 1'b1;
        #1;
        checkOutput("b2bOverlap", {31'd0, stallD}, 32'd1);
        applyStimulus();
        MultStartE = 1'b0; MultDoneE = 1'b0; MultStartD = 1'b0;
        #1;
        checkOutput("b2bBusy", {31'd0, multBusy}, 32'd1);
        MultDoneE = 1'b1;
        applyStimulus();
        MultDoneE = 1'b0;
        #1;
        checkOutput("b2bIdle", {31'd0, multBusy}, 32'd0);

        // Watchdog: eight BUSY cycles without done, then sticky error
        MultStartE = 1'b1;
        applyStimulus();
        MultStartE = 1'b0;
        #1;
        checkOutput("wdBusy1", {30'd0, multBusy, multTimeout}, 32'd2);
        for (int i = 2; i <= TIMEOUT; i++) begin
            applyStimulus();
            #1;
            checkOutput($sformatf("wdBusy%0d", i), {30'd0, multBusy, multTimeout}, 32'd2);
        end
        applyStimulus();
        #1;
        checkOutput("wdFired", {30'd0, multBusy, multTimeout}, 32'd1);
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("wdSticky", {30'd0, multBusy, multTimeout}, 32'd1);

        // Asynchronous reset mid-multiply
        MultStartE = 1'b1;
        applyStimulus();
        MultStartE = 1'b0;
        #1;
        checkOutput("rstPreBusy", {31'd0, multBusy}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rstAsync", {30'd0, multBusy, multTimeout}, 32'd0);
        checkOutput("rstOuts", {22'd0, stallF, stallD, flushE, forwardAD, forwardBD,
                    forwardAE, forwardBE, multBusy, multTimeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
        #1;
        checkOutput("perfReset", perfStallCycles | perfMultStall, 32'd0);
        applyStimulus();
        WBSrcE = 3'b001; RegWriteE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
        repeat (10) applyStimulus();
        clearInputs();
        #1;
        checkOutput("perfStall", perfStallCycles, 32'd10);
        checkOutput("perfMult", perfMultStall, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
